// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file with a busy scoreboard for RAW/WAW stalls.
// Define WB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
module regfile_wb_arbiter #(
  parameter int n    = 32,
  parameter int m    = 5,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*m-1:0] req_addr,
  input  logic [NREQ*n-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              regWrite,
  output logic [m-1:0]      writeReg,
  output logic [n-1:0]      writeData,
  input  logic              iss_valid,
  input  logic [m-1:0]      iss_rd,
  output logic              iss_ready,
  input  logic [m-1:0]      rs1_addr,
  input  logic [m-1:0]      rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              flush
);
  localparam int NREG = 1 << m;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [m-1:0]    addr_arr [NREQ];
  logic [n-1:0]    data_arr [NREQ];
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] x0_req;
  logic [NREQ-1:0] sel;
  logic [NREQ-1:0] grant_oh;
  logic            grant_any;
  logic [m-1:0]    acc_addr [NREQ+1];
  logic [n-1:0]    acc_data [NREQ+1];
  logic [m-1:0]    grant_addr;
  logic [n-1:0]    grant_data;
  logic [NREG-1:0] busy_reg, busy_next;

  // Everything is gated by rst so nothing is accepted while held in reset.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*m +: m];
      assign data_arr[gi] = req_data[gi*n +: n];
      assign cand[gi]     = rst && req_valid[gi] && (addr_arr[gi] != '0);
      assign x0_req[gi]   = rst && req_valid[gi] && (addr_arr[gi] == '0);
    end
  endgenerate

`ifdef WB_RR_EN
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] cand_hi;
  logic [PW-1:0]   acc_next [NREQ+1];

  // Candidates at or above the pointer take precedence; otherwise wrap to the bottom.
  assign cand_hi = cand & ({NREQ{1'b1}} << ptr_reg);
  assign sel     = (cand_hi != '0) ? cand_hi : cand;

  assign acc_next[0] = '0;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ptr
      assign acc_next[gi+1] = acc_next[gi] | (grant_oh[gi] ? PW'((gi + 1) % NREQ) : '0);
    end
  endgenerate

  assign ptr_next = grant_any ? acc_next[NREQ] : ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end
`else
  assign sel = cand;
`endif

  // Isolate the lowest set bit of the selected candidate set.
  assign grant_oh  = sel & (~sel + NREQ'(1));
  assign grant_any = |cand;

  assign acc_addr[0] = '0;
  assign acc_data[0] = '0;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mux
      assign acc_addr[gi+1] = acc_addr[gi] | (grant_oh[gi] ? addr_arr[gi] : '0);
      assign acc_data[gi+1] = acc_data[gi] | (grant_oh[gi] ? data_arr[gi] : '0);
    end
  endgenerate
  assign grant_addr = acc_addr[NREQ];
  assign grant_data = acc_data[NREQ];

  assign req_ready = grant_oh | x0_req;
  assign iss_ready = rst && !busy_reg[iss_rd];
  assign rs1_busy  = busy_reg[rs1_addr];
  assign rs2_busy  = busy_reg[rs2_addr];

  // Order matters: issue set overrides writeback clear, flush overrides both.
  always_comb begin
    busy_next = busy_reg;
    if (grant_any) busy_next[grant_addr] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg  <= '0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      busy_reg <= busy_next;
      regWrite <= grant_any;
      if (grant_any) begin
        writeReg  <= grant_addr;
        writeData <= grant_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed corner sequences,
// and a randomized phase against a scoreboard model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int N    = 32;
  localparam int M    = 5;
  localparam int NREQ = 3;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*M-1:0] req_addr;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              regWrite;
  logic [M-1:0]      writeReg;
  logic [N-1:0]      writeData;
  logic              iss_valid;
  logic [M-1:0]      iss_rd;
  logic              iss_ready;
  logic [M-1:0]      rs1_addr, rs2_addr;
  logic              rs1_busy, rs2_busy;
  logic              flush;

  regfile_wb_arbiter #(.n(N), .m(M), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'h3333_0002;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[i*M +: M] = a;
    req_data[i*N +: N] = d;
  endtask

  task automatic idle();
    req_valid = '0;
    iss_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Sweeps every register through both operand ports well inside one clock phase.
  task automatic sweep(input string name, input logic [31:0] exp);
    logic [31:0] b1, b2;
    b1 = '0;
    b2 = '0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[4:0];
      rs2_addr = 5'(31 - a);
      #0.1;
      b1[a]      = rs1_busy;
      b2[31 - a] = rs2_busy;
    end
    chk({name, "_rs1"}, b1, exp);
    chk({name, "_rs2"}, b2, exp);
  endtask

  vec_t vecs [9];

  // Scoreboard model state for the randomized phase.
  bit          mbusy [32];
  int          mptr;
  bit          pend  [NREQ];
  logic [4:0]  paddr [NREQ];
  logic [31:0] pdata [NREQ];

  initial begin
    vecs[0] = '{3'b001,  5, 0,  0, 3'b001, 1,  5, D0};
    vecs[1] = '{3'b010,  0, 12, 0, 3'b010, 1, 12, D1};
    vecs[2] = '{3'b100,  0, 0, 31, 3'b100, 1, 31, D2};
    vecs[3] = '{3'b110,  0, 0,  7, 3'b110, 1,  7, D2};
    vecs[4] = '{3'b011,  0, 17, 0, 3'b011, 1, 17, D1};
    vecs[5] = '{3'b111,  0, 0,  0, 3'b111, 0,  0, 0};
    vecs[6] = '{3'b000,  4, 5,  6, 3'b000, 0,  0, 0};
    vecs[7] = '{3'b101,  0, 9,  0, 3'b101, 0,  0, 0};
    vecs[8] = '{3'b101, 20, 9,  0, 3'b101, 1, 20, D0};

    // Reset with every input active.
    rst = 1'b0;
    req_valid = '1;
    drive_req(0, 1'b1, 5'd1, D0);
    drive_req(1, 1'b1, 5'd2, D1);
    drive_req(2, 1'b1, 5'd3, D2);
    iss_valid = 1'b1; iss_rd = 5'd9; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    step();
    step();
    chk("rst_regWrite", regWrite, 0);
    chk("rst_writeReg", writeReg, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_iss_ready", iss_ready, 0);
    idle();
    rst = 1'b1;
    iss_rd = '0;
    #1;
    chk("iss_ready_x0", iss_ready, 1);
    sweep("busy_after_rst", 32'h0);
    step();

    // Table of single-cycle arbitration vectors, each with at most one real candidate.
    foreach (vecs[v]) begin
      drive_req(0, vecs[v].valid[0], vecs[v].a0, D0);
      drive_req(1, vecs[v].valid[1], vecs[v].a1, D1);
      drive_req(2, vecs[v].valid[2], vecs[v].a2, D2);
      #1;
      chk($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
      step();
      idle();
      chk($sformatf("vec%0d_regWrite", v), regWrite, vecs[v].exp_we);
      if (vecs[v].exp_we) begin
        chk($sformatf("vec%0d_writeReg", v), writeReg, vecs[v].exp_reg);
        chk($sformatf("vec%0d_writeData", v), writeData, vecs[v].exp_data);
      end
      $display("vec %0d valid=%b ready=%b we=%0d reg=%0d", v, vecs[v].valid, req_ready, regWrite, writeReg);
    end

    // Single writeback through the scoreboard.
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
    #1;
    chk("wb_iss_ready", iss_ready, 1);
    chk("wb_busy_t0", rs1_busy, 0);
    step();
    iss_valid = 1'b0;
    chk("wb_busy_t1", rs1_busy, 1);
    step();
    step();
    drive_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("wb_ready_t3", req_ready, 3'b001);
    chk("wb_no_bypass", rs1_busy, 1);
    step();
    idle();
    chk("wb_regWrite", regWrite, 1);
    chk("wb_writeReg", writeReg, 5);
    chk("wb_writeData", writeData, 32'hDEADBEEF);
    chk("wb_busy_t4", rs1_busy, 0);
    $display("single writeback reg=%0d data=%h", writeReg, writeData);

    // Contention from a fresh pointer.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      int w;
      drive_req(0, 1'b1, 5'd1, D0);
      drive_req(1, 1'b1, 5'd2, D1);
      drive_req(2, 1'b1, 5'd3, D2);
      w = RR ? (c % 3) : 0;
      #1;
      chk($sformatf("cont%0d_ready", c), req_ready, 3'(1 << w));
      step();
      chk($sformatf("cont%0d_writeReg", c), writeReg, w + 1);
      $display("contention cycle %0d grant reg=%0d", c, writeReg);
    end
    idle();

    // Hazards: WAW stall, then same-cycle set and clear.
    iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9;
    #1;
    chk("haz_first_iss", iss_ready, 1);
    step();
    chk("haz_busy9", rs1_busy, 1);
    chk("haz_waw_stall", iss_ready, 0);
    iss_valid = 1'b0;
    drive_req(1, 1'b1, 5'd9, D1);
    #1;
    chk("haz_clear_ready", req_ready, 3'b010);
    step();
    idle();
    chk("haz_cleared", rs1_busy, 0);
    drive_req(2, 1'b1, 5'd9, D2);
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    chk("haz_same_iss", iss_ready, 1);
    chk("haz_same_ready", req_ready, 3'b100);
    step();
    idle();
    chk("haz_same_writeReg", writeReg, 9);
    chk("haz_set_wins", rs1_busy, 1);
    drive_req(0, 1'b1, 5'd9, D0);
    step();
    idle();
    chk("haz_final_clear", rs1_busy, 0);
    $display("hazard sequence done");

    // Flush with a pending writeback and a same-cycle issue.
    iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    iss_rd = 5'd6;
    step();
    iss_valid = 1'b0;
    rs2_addr = 5'd6;
    #0.1;
    chk("flush_pre_busy6", rs2_busy, 1);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
    drive_req(0, 1'b1, 5'd4, 32'h0000_0044);
    #1;
    chk("flush_iss_ready", iss_ready, 1);
    step();
    idle();
    chk("flush_regWrite", regWrite, 1);
    chk("flush_writeReg", writeReg, 4);
    sweep("flush_busy", 32'h0);
    $display("flush sequence done");

    // Reset during traffic discards the grant.
    drive_req(0, 1'b1, 5'd3, D0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 0);
    step();
    chk("midrst_regWrite", regWrite, 0);
    idle();
    rst = 1'b1;
    step();

    // Randomized traffic checked against the scoreboard model.
    rst = 1'b0;
    step();
    rst = 1'b1;
    mptr = 0;
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int          win;
      logic [2:0]  exp_ready;
      bit          iss_acc;
      logic [4:0]  iss_cur;
      bit          fl_cur;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
          pdata[i] = $urandom;
        end
        drive_req(i, pend[i], paddr[i], pdata[i]);
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 15));
      rs1_addr  = 5'($urandom_range(0, 15));
      rs2_addr  = 5'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      win = -1;
      exp_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = RR ? ((mptr + k) % NREQ) : k;
        if (pend[i] && paddr[i] == 0) exp_ready[i] = 1'b1;
        if (pend[i] && paddr[i] != 0 && win < 0) win = i;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      chk($sformatf("rnd%0d_ready", cyc), req_ready, exp_ready);
      chk($sformatf("rnd%0d_iss_ready", cyc), iss_ready, !mbusy[iss_rd]);
      chk($sformatf("rnd%0d_rs1_busy", cyc), rs1_busy, mbusy[rs1_addr]);
      chk($sformatf("rnd%0d_rs2_busy", cyc), rs2_busy, mbusy[rs2_addr]);
      iss_cur = iss_rd;
      fl_cur  = flush;
      iss_acc = iss_valid && !mbusy[iss_rd] && iss_rd != 0;
      step();
      chk($sformatf("rnd%0d_regWrite", cyc), regWrite, win >= 0);
      if (win >= 0) begin
        chk($sformatf("rnd%0d_writeReg", cyc), writeReg, paddr[win]);
        chk($sformatf("rnd%0d_writeData", cyc), writeData, pdata[win]);
        $display("rnd %0d grant=%0d reg=%0d data=%h", cyc, win, paddr[win], pdata[win]);
        mbusy[paddr[win]] = 1'b0;
        mptr = (win + 1) % NREQ;
        pend[win] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++)
        if (exp_ready[i]) pend[i] = 1'b0;
      if (iss_acc) mbusy[iss_cur] = 1'b1;
      if (fl_cur) foreach (mbusy[i]) mbusy[i] = 1'b0;
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
